// File: rtl/fixpu_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : FixSched_pkg
// Brief   : Shared types and default sizes for the FixPU round-robin
//           scheduler (Q8.16 operands, four requesters).
// Revision: 1.0 - initial release
// ============================================================================
package FixSched_pkg;

    localparam int c_NREQ  = 4;
    localparam int c_NINT  = 8;
    localparam int c_NMANT = 16;
    localparam int c_W     = c_NINT + c_NMANT;

    typedef logic signed [c_W-1:0] fix_t;

    // In-flight tag: valid flag plus the id of the requester that issued it
    typedef struct packed {
        logic                      v;
        logic [$clog2(c_NREQ)-1:0] id;
    } tag_t;

endpackage : FixSched_pkg
`default_nettype wire

// File: rtl/fixpu_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin priority picker. Grants the first
//           requester found when searching from i_ptr upwards, modulo N.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import FixSched_pkg::*;
#(
    parameter int N = c_NREQ
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic                 o_found,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int c_IdW = $clog2(N);

    // Index ptr+k wrapped into 0..N-1 (both terms are already below N)
    function automatic logic [c_IdW-1:0] wrapIdx(input logic [c_IdW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return c_IdW'(s);
    endfunction

    // Search ptr, ptr+1, ... and keep the first active request
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!o_found && i_req[wrapIdx(i_ptr, k)]) begin
                o_found = 1'b1;
                o_idx   = wrapIdx(i_ptr, k);
            end
        end
        if (o_found) o_grant[o_idx] = 1'b1;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fixpu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : fixpu_rr_scheduler
// Brief   : Time-shares one pipelined fixed-point multiplier among N_REQ
//           requesters. One operand pair is granted per cycle round-robin;
//           each product returns to its issuer LAT+1 cycles later.
// Revision: 1.0 - initial release
// ============================================================================
module fixpu_rr_scheduler
    import FixSched_pkg::*;
#(
    parameter int N_REQ  = c_NREQ,
    parameter int N_INT  = c_NINT,
    parameter int N_MANT = c_NMANT,
    parameter int LAT    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_REQ-1:0]                        req_valid,
    input  logic [N_REQ-1:0][N_INT+N_MANT-1:0]      req_a,
    input  logic [N_REQ-1:0][N_INT+N_MANT-1:0]      req_b,
    output logic [N_REQ-1:0]                        req_ready,
    output logic [N_INT+N_MANT-1:0]                 pu_a,
    output logic [N_INT+N_MANT-1:0]                 pu_b,
    input  logic [N_INT+N_MANT-1:0]                 pu_result,
    output logic [N_REQ-1:0]                        rsp_valid,
    output logic [N_INT+N_MANT-1:0]                 rsp_data,
    output logic                                    busy
);

    localparam int c_IdW = $clog2(N_REQ);

    typedef struct packed {
        logic             v;
        logic [c_IdW-1:0] id;
    } schedTag_t;

    logic [c_IdW-1:0]     r_ptr;
    schedTag_t [LAT:0]    r_tagPipe;
    logic [N_REQ-1:0]     w_grant;
    logic                 w_found;
    logic [c_IdW-1:0]     w_grantIdx;
    logic [c_IdW-1:0]     w_nextPtr;
    schedTag_t            w_newTag;
    schedTag_t            w_head;

    rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_found (w_found),
        .o_idx   (w_grantIdx)
    );

    // Ready is suppressed while reset is held so nothing is accepted then
    assign req_ready = w_grant & {N_REQ{rst}};

    assign w_nextPtr = (w_grantIdx == c_IdW'(N_REQ - 1)) ? '0 : w_grantIdx + c_IdW'(1);
    assign w_newTag  = '{v: w_found, id: w_grantIdx};
    assign w_head    = r_tagPipe[LAT];

    // Pointer, operand stage and tag shift register; reset drops in-flight work
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr     <= '0;
            pu_a      <= '0;
            pu_b      <= '0;
            r_tagPipe <= '0;
        end else begin
            if (w_found) begin
                r_ptr <= w_nextPtr;
                pu_a  <= req_a[w_grantIdx];
                pu_b  <= req_b[w_grantIdx];
            end
            r_tagPipe <= {r_tagPipe[LAT-1:0], w_newTag};
        end
    end

    // Head of the tag pipe lines up with the multiplier output
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (w_head.v) begin
            rsp_valid[w_head.id] = 1'b1;
            rsp_data             = pu_result;
        end
    end

    // Busy whenever any tag slot holds a live product
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= LAT; k++) busy = busy | r_tagPipe[k].v;
    end

endmodule : fixpu_rr_scheduler
`default_nettype wire

// File: tb/tb_fixpu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_fixpu_rr_scheduler
// Brief   : Self-checking bench for fixpu_rr_scheduler with a behavioural
//           two-stage Q8.16 multiplier standing in for FixPU.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fixpu_rr_scheduler;

    localparam int N_REQ = 4;
    localparam int LAT   = 2;
    localparam int W     = 24;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [N_REQ-1:0]           req_valid = '0;
    logic [N_REQ-1:0][W-1:0]    req_a = '0;
    logic [N_REQ-1:0][W-1:0]    req_b = '0;
    logic [N_REQ-1:0]           req_ready;
    logic [W-1:0]               pu_a, pu_b, pu_result;
    logic [N_REQ-1:0]           rsp_valid;
    logic [W-1:0]               rsp_data;
    logic                       busy;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    fixpu_rr_scheduler #(
        .N_REQ  (N_REQ),
        .N_INT  (8),
        .N_MANT (16),
        .LAT    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .pu_a      (pu_a),
        .pu_b      (pu_b),
        .pu_result (pu_result),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Q8.16 product, truncated
    function automatic logic [W-1:0] fixMul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p[W+15:16];
    endfunction

    // Stand-in FixPU: LAT-stage pipeline
    logic [W-1:0] puPipe [0:LAT-1];
    always_ff @(posedge clk) begin
        puPipe[0] <= fixMul(pu_a, pu_b);
        for (int k = 1; k < LAT; k++) puPipe[k] <= puPipe[k-1];
    end
    assign pu_result = puPipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            if (nFails <= 20) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, sample on the falling edge
    task automatic cyc(input logic [3:0] v, input logic r);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]   v;
        logic [3:0]   rdy;
        logic [3:0]   rspV;
        logic [W-1:0] rspD;
        logic         bsy;
    } vec_t;
    vec_t tbl [16];

    typedef struct {
        int           id;
        logic [W-1:0] d;
        int           due;
    } sb_t;
    sb_t sbq [$];

    logic [3:0] pend;
    int         waitC [N_REQ];

    initial begin
        // Fixed operands: 1.0*2.5, -2.0*3.0, 0.5*0.5, -1.5*-4.0
        req_a[0] = 24'h010000; req_b[0] = 24'h028000;
        req_a[1] = 24'hFE0000; req_b[1] = 24'h030000;
        req_a[2] = 24'h008000; req_b[2] = 24'h008000;
        req_a[3] = 24'hFE8000; req_b[3] = 24'hFC0000;

        //             valid    ready    rspV     rspD         busy
        tbl[0]  = '{4'b1111, 4'b0001, 4'b0000, 24'h000000, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0010, 4'b0000, 24'h000000, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0100, 4'b0000, 24'h000000, 1'b1};
        tbl[3]  = '{4'b1111, 4'b1000, 4'b0001, 24'h028000, 1'b1};
        tbl[4]  = '{4'b1111, 4'b0001, 4'b0010, 24'hFA0000, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0100, 24'h004000, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 4'b1000, 24'h060000, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0001, 24'h028000, 1'b1};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0000, 24'h000000, 1'b0};
        tbl[9]  = '{4'b1010, 4'b1000, 4'b0000, 24'h000000, 1'b1};
        tbl[10] = '{4'b1010, 4'b0010, 4'b0000, 24'h000000, 1'b1};
        tbl[11] = '{4'b1010, 4'b1000, 4'b0100, 24'h004000, 1'b1};
        tbl[12] = '{4'b0000, 4'b0000, 4'b1000, 24'h060000, 1'b1};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0010, 24'hFA0000, 1'b1};
        tbl[14] = '{4'b0000, 4'b0000, 4'b1000, 24'h060000, 1'b1};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 24'h000000, 1'b0};

        // Reset state
        cyc(4'b1111, 1'b0);
        cyc(4'b1111, 1'b0);
        check("reset_ready", 32'(req_ready), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_data", 32'(rsp_data), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_pu_a", 32'(pu_a), 32'(0));
        check("reset_pu_b", 32'(pu_b), 32'(0));

        // Round-robin over all four, wrap past index 3, busy and ordering
        for (int k = 0; k < 16; k++) begin
            cyc(tbl[k].v, 1'b1);
            check($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
            check($sformatf("tbl%0d_rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].rspV));
            check($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].bsy));
            if (tbl[k].rspV != 4'b0000)
                check($sformatf("tbl%0d_rsp_data", k), 32'(rsp_data), 32'(tbl[k].rspD));
        end

        // Single requester: ready same cycle, product LAT+1 cycles later
        cyc(4'b0001, 1'b1);
        check("single_ready", 32'(req_ready), 32'(4'b0001));
        cyc(4'b0000, 1'b1);
        check("single_pu_a", 32'(pu_a), 32'(24'h010000));
        check("single_pu_b", 32'(pu_b), 32'(24'h028000));
        check("single_wait1", 32'(rsp_valid), 32'(0));
        cyc(4'b0000, 1'b1);
        check("single_wait2", 32'(rsp_valid), 32'(0));
        check("single_busy", 32'(busy), 32'(1));
        cyc(4'b0000, 1'b1);
        check("single_rsp_valid", 32'(rsp_valid), 32'(4'b0001));
        check("single_rsp_data", 32'(rsp_data), 32'(24'h028000));
        cyc(4'b0000, 1'b1);
        check("single_busy_low", 32'(busy), 32'(0));

        // Reset mid-flight: ptr=1 -> grants 1,2,3,0, leaving ptr=1
        cyc(4'b1111, 1'b1); check("rst_g1", 32'(req_ready), 32'(4'b0010));
        cyc(4'b1111, 1'b1); check("rst_g2", 32'(req_ready), 32'(4'b0100));
        cyc(4'b1111, 1'b1); check("rst_g3", 32'(req_ready), 32'(4'b1000));
        cyc(4'b1111, 1'b1); check("rst_g0", 32'(req_ready), 32'(4'b0001));
        cyc(4'b1111, 1'b0); check("rst_ready_gated", 32'(req_ready), 32'(0));
        cyc(4'b1111, 1'b0);
        check("rst_mid_ready", 32'(req_ready), 32'(0));
        check("rst_mid_rsp", 32'(rsp_valid), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_data", 32'(rsp_data), 32'(0));
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0000, 1'b1);
            check($sformatf("rst_after%0d_rsp", k), 32'(rsp_valid), 32'(0));
            check($sformatf("rst_after%0d_busy", k), 32'(busy), 32'(0));
        end
        cyc(4'b0101, 1'b1);
        check("rst_first_grant", 32'(req_ready), 32'(4'b0001));
        for (int k = 0; k < 5; k++) cyc(4'b0000, 1'b1);

        // Random valid/stall stress against a scoreboard
        pend = '0;
        for (int i = 0; i < N_REQ; i++) waitC[i] = 0;
        for (int t = 0; t < 24012; t++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (t < 24000 && !pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    req_a[i] = 24'($urandom);
                    req_b[i] = 24'($urandom);
                    waitC[i] = 0;
                end
            end
            req_valid = pend;
            @(negedge clk);
            check("stress_ready_onehot",
                  32'(((req_ready & (req_ready - 4'd1)) == 4'd0) && ((req_ready & ~req_valid) == 4'd0)),
                  32'(1));
            if (sbq.size() > 0 && sbq[0].due == t) begin
                check("stress_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << sbq[0].id));
                check("stress_rsp_data", 32'(rsp_data), 32'(sbq[0].d));
                void'(sbq.pop_front());
            end else begin
                check("stress_rsp_idle", 32'(rsp_valid), 32'(0));
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    sbq.push_back('{id: i, d: fixMul(req_a[i], req_b[i]), due: t + LAT + 1});
                    pend[i] = 1'b0;
                end else if (pend[i]) begin
                    waitC[i]++;
                    check("stress_starvation", 32'(waitC[i] <= N_REQ), 32'(1));
                end
            end
        end
        check("stress_drained", 32'(sbq.size()), 32'(0));
        check("stress_pending", 32'(pend), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_fixpu_rr_scheduler
`default_nettype wire
